// File: rtl/ast_window_gen.sv
// -----------------------------------------------------------------------------
// ast_window_gen
//
// Converts a packetised Avalon-ST byte stream (AST_SINK_SYMBOLS bytes per beat)
// into per-beat sets of AST_SINK_SYMBOLS sliding windows, one window starting
// at each byte position of the output beat. The window length is selected per
// packet (sampled with SOP). Packets can be dropped via en_i.
//
// Storage is DEPTH+1 beat slots. New beats enter slot DEPTH and everything moves
// down one slot; slot 0 is the beat presented on the window output. The slots
// above slot 0 provide the look-ahead bytes that complete the windows.
//
// Ports:
//   clk_i                     clock
//   arst_n_i                  asynchronous active-low reset
//   en_i                      sampled with SOP; 0 drops the whole packet
//   win_size_i                window length, sampled with SOP (0 or >MAX -> MAX)
//   ast_sink_*                Avalon-ST sink (data, ready, valid, empty, sop, eop)
//   windows_data_o            window i, byte j at bits [(i*MAX_WINDOW_SIZE+j)*8 +: 8];
//                             byte 0 is the window's first stream byte
//   windows_valid_bytes_o     valid length of window i at [i*WINDOW_SIZE_W +: WINDOW_SIZE_W]
//   windows_sop_o             beat holds the first bytes of the packet
//   windows_eop_o             last output beat of the packet
//   windows_valid_o           output beat valid
//   windows_ready_i           output beat accepted
//
// Configuration macro:
//   AST_WINDOW_GEN_PARTIAL_EN  defined: tail windows report their shortened length.
//                              undefined: only full-length windows report a length,
//                              shorter ones report 0 (beats are still presented).
// -----------------------------------------------------------------------------
module ast_window_gen #(
    parameter int unsigned AST_SINK_SYMBOLS = 8,
    parameter int unsigned AST_SINK_ORDER   = 1,
    parameter int unsigned AST_SINK_EMPTY_W =
        (AST_SINK_SYMBOLS > 1) ? $clog2(AST_SINK_SYMBOLS) : 1,
    parameter int unsigned MAX_WINDOW_SIZE  = 20,
    parameter int unsigned WINDOW_SIZE_W    = $clog2(MAX_WINDOW_SIZE + 1)
) (
    input  logic                                          clk_i,
    input  logic                                          arst_n_i,
    input  logic                                          en_i,
    input  logic [WINDOW_SIZE_W-1:0]                      win_size_i,
    input  logic [AST_SINK_SYMBOLS*8-1:0]                 ast_sink_data_i,
    output logic                                          ast_sink_ready_o,
    input  logic                                          ast_sink_valid_i,
    input  logic [AST_SINK_EMPTY_W-1:0]                   ast_sink_empty_i,
    input  logic                                          ast_sink_startofpacket_i,
    input  logic                                          ast_sink_endofpacket_i,
    output logic [AST_SINK_SYMBOLS*MAX_WINDOW_SIZE*8-1:0] windows_data_o,
    output logic [AST_SINK_SYMBOLS*WINDOW_SIZE_W-1:0]     windows_valid_bytes_o,
    output logic                                          windows_sop_o,
    output logic                                          windows_eop_o,
    output logic                                          windows_valid_o,
    input  logic                                          windows_ready_i
);

    localparam int unsigned N       = AST_SINK_SYMBOLS;
    // ceil((MAX_WINDOW_SIZE-1)/N) look-ahead beats
    localparam int unsigned DEPTH   = (MAX_WINDOW_SIZE + N - 2) / N;
    localparam int unsigned SLOTS   = DEPTH + 1;
    localparam int unsigned N_BYTES = SLOTS * N;
    localparam int unsigned CNT_W   = $clog2(N + 1);
    localparam int unsigned SUM_W   = $clog2(N_BYTES + 1);

    typedef enum logic [1:0] {
        StRun,
        StFlush,
        StDrop
    } state_e;

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    state_e                   r_state;
    logic [N-1:0][7:0]        r_data [SLOTS];
    logic [CNT_W-1:0]         r_cnt  [SLOTS];
    logic [SLOTS-1:0]         r_sop;
    logic [WINDOW_SIZE_W-1:0] r_win;
    logic                     r_pkt_open;

    // ---------------------------------------------------------------------
    // Wires
    // ---------------------------------------------------------------------
    logic [N-1:0][7:0]        w_in_data;
    logic [CNT_W-1:0]         w_in_cnt;
    logic [WINDOW_SIZE_W-1:0] w_win_clamped;
    logic [SUM_W-1:0]         w_total;
    logic [7:0]               w_flat [N_BYTES];
    logic                     w_out_free;
    logic                     w_accept;
    logic                     w_start;
    logic                     w_drop;
    logic                     w_body;
    logic                     w_shift;
    logic                     w_tail_empty;

    // Symbol 0 is always the first stream byte inside the slots.
    for (genvar s = 0; s < N; s++) begin : g_in_order
        if (AST_SINK_ORDER != 0) begin : g_msb_first
            assign w_in_data[s] = ast_sink_data_i[(N-1-s)*8 +: 8];
        end else begin : g_lsb_first
            assign w_in_data[s] = ast_sink_data_i[s*8 +: 8];
        end
    end

    // Byte count of the entering beat. An out-of-range empty value still
    // leaves one byte so the eop beat can always be recognised on output.
    always_comb begin
        w_in_cnt = CNT_W'(N);
        if (ast_sink_endofpacket_i) begin
            if (int'(ast_sink_empty_i) >= int'(N)) begin
                w_in_cnt = CNT_W'(1);
            end else begin
                w_in_cnt = CNT_W'(int'(N) - int'(ast_sink_empty_i));
            end
        end
    end

    always_comb begin
        w_win_clamped = win_size_i;
        if (win_size_i == '0 || int'(win_size_i) > int'(MAX_WINDOW_SIZE)) begin
            w_win_clamped = WINDOW_SIZE_W'(MAX_WINDOW_SIZE);
        end
    end

    // ---------------------------------------------------------------------
    // Handshake and shift control
    // ---------------------------------------------------------------------
    assign windows_valid_o = (r_cnt[0] != '0);
    assign windows_sop_o   = r_sop[0];
    assign w_out_free      = !windows_valid_o || windows_ready_i;

    always_comb begin
        w_tail_empty = 1'b1;
        for (int k = 1; k <= DEPTH; k++) begin
            if (r_cnt[k] != '0) begin
                w_tail_empty = 1'b0;
            end
        end
    end

    assign windows_eop_o = windows_valid_o && w_tail_empty && (r_state == StFlush);

    always_comb begin
        ast_sink_ready_o = 1'b0;
        unique case (r_state)
            StRun:   ast_sink_ready_o = w_out_free;
            StFlush: ast_sink_ready_o = 1'b0;
            StDrop:  ast_sink_ready_o = 1'b1;
            default: ast_sink_ready_o = 1'b0;
        endcase
    end

    assign w_accept = ast_sink_valid_i && ast_sink_ready_o;
    assign w_start  = w_accept && (r_state == StRun) && ast_sink_startofpacket_i && en_i;
    assign w_drop   = w_accept && (r_state == StRun) && ast_sink_startofpacket_i && !en_i;
    // Non-SOP beats only enter while a packet is open; stray beats are consumed.
    assign w_body   = w_accept && (r_state == StRun) && !ast_sink_startofpacket_i &&
                      r_pkt_open;
    // In RUN an accepted beat already implies the output slot is free.
    assign w_shift  = ((r_state == StRun) && (w_start || w_body)) ||
                      ((r_state == StFlush) && w_out_free);

    // ---------------------------------------------------------------------
    // Control state: FSM, byte counts, sop flags, latched window size
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_state    <= StRun;
            r_sop      <= '0;
            r_win      <= WINDOW_SIZE_W'(MAX_WINDOW_SIZE);
            r_pkt_open <= 1'b0;
            for (int k = 0; k < SLOTS; k++) begin
                r_cnt[k] <= '0;
            end
        end else begin
            if (w_shift) begin
                // A new packet discards whatever look-ahead bytes are left.
                for (int k = 0; k < DEPTH; k++) begin
                    r_cnt[k] <= w_start ? '0   : r_cnt[k+1];
                    r_sop[k] <= w_start ? 1'b0 : r_sop[k+1];
                end
                r_cnt[DEPTH] <= (r_state == StFlush) ? '0 : w_in_cnt;
                r_sop[DEPTH] <= w_start;
            end

            unique case (r_state)
                StRun: begin
                    if (w_start) begin
                        r_win      <= w_win_clamped;
                        r_pkt_open <= !ast_sink_endofpacket_i;
                        if (ast_sink_endofpacket_i) begin
                            r_state <= StFlush;
                        end
                    end else if (w_drop) begin
                        r_pkt_open <= 1'b0;
                        if (!ast_sink_endofpacket_i) begin
                            r_state <= StDrop;
                        end
                    end else if (w_body && ast_sink_endofpacket_i) begin
                        r_pkt_open <= 1'b0;
                        r_state    <= StFlush;
                    end
                end
                StFlush: begin
                    // The shift that retires the eop beat ends the flush.
                    if (w_shift && windows_eop_o) begin
                        r_state <= StRun;
                    end
                end
                StDrop: begin
                    if (w_accept && ast_sink_endofpacket_i) begin
                        r_state <= StRun;
                    end
                end
                default: r_state <= StRun;
            endcase
        end
    end

    // Slot payload is qualified by r_cnt, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (w_shift) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_data[k] <= r_data[k+1];
            end
            r_data[DEPTH] <= w_in_data;
        end
    end

    // ---------------------------------------------------------------------
    // Window data: slots viewed as one flat byte stream starting at slot 0
    // ---------------------------------------------------------------------
    always_comb begin
        for (int k = 0; k < SLOTS; k++) begin
            for (int b = 0; b < N; b++) begin
                w_flat[k*N+b] = r_data[k][b];
            end
        end
    end

    // Highest index used is N-1+MAX_WINDOW_SIZE-1, which DEPTH guarantees is
    // inside the flat buffer.
    for (genvar i = 0; i < N; i++) begin : g_win
        for (genvar j = 0; j < MAX_WINDOW_SIZE; j++) begin : g_byte
            assign windows_data_o[(i*MAX_WINDOW_SIZE+j)*8 +: 8] = w_flat[i+j];
        end
    end

    // ---------------------------------------------------------------------
    // Valid length per window
    // ---------------------------------------------------------------------
    always_comb begin
        w_total = '0;
        for (int k = 0; k < SLOTS; k++) begin
            w_total = w_total + SUM_W'(r_cnt[k]);
        end
    end

    always_comb begin
        int rem;
        int vb;
        rem = 0;
        vb  = 0;
        windows_valid_bytes_o = '0;
        for (int i = 0; i < N; i++) begin
            rem = int'(w_total) - i;
            vb  = 0;
            if (i < int'(r_cnt[0])) begin
`ifdef AST_WINDOW_GEN_PARTIAL_EN
                vb = (rem < int'(r_win)) ? rem : int'(r_win);
`else
                vb = (rem < int'(r_win)) ? 0 : int'(r_win);
`endif
            end
            windows_valid_bytes_o[i*WINDOW_SIZE_W +: WINDOW_SIZE_W] = WINDOW_SIZE_W'(vb);
        end
    end

endmodule

// File: tb/tb_ast_window_gen.sv
// -----------------------------------------------------------------------------
// tb_ast_window_gen
//
// Scoreboard bench for ast_window_gen (4 symbols, 8-byte max window, depth 2).
// Stimulus pushes hand-computed expected output beats into a queue; a monitor
// pops and compares every beat the DUT hands over (valid && ready).
// Packet bytes are consecutive values from a base, so window i byte j of a beat
// starting at byte s must equal s+i+j.
// -----------------------------------------------------------------------------
module tb_ast_window_gen;

    localparam int unsigned SYM = 4;
    localparam int unsigned MAXW = 8;
    localparam int unsigned WSW = 4;
    localparam int unsigned EW = 2;

`ifdef AST_WINDOW_GEN_PARTIAL_EN
    localparam bit Partial = 1'b1;
`else
    localparam bit Partial = 1'b0;
`endif

    logic                     clk_i;
    logic                     arst_n_i;
    logic                     en_i;
    logic [WSW-1:0]           win_size_i;
    logic [SYM*8-1:0]         ast_sink_data_i;
    logic                     ast_sink_ready_o;
    logic                     ast_sink_valid_i;
    logic [EW-1:0]            ast_sink_empty_i;
    logic                     ast_sink_startofpacket_i;
    logic                     ast_sink_endofpacket_i;
    logic [SYM*MAXW*8-1:0]    windows_data_o;
    logic [SYM*WSW-1:0]       windows_valid_bytes_o;
    logic                     windows_sop_o;
    logic                     windows_eop_o;
    logic                     windows_valid_o;
    logic                     windows_ready_i;

    ast_window_gen #(
        .AST_SINK_SYMBOLS (SYM),
        .MAX_WINDOW_SIZE  (MAXW)
    ) dut (
        .clk_i                    (clk_i),
        .arst_n_i                 (arst_n_i),
        .en_i                     (en_i),
        .win_size_i               (win_size_i),
        .ast_sink_data_i          (ast_sink_data_i),
        .ast_sink_ready_o         (ast_sink_ready_o),
        .ast_sink_valid_i         (ast_sink_valid_i),
        .ast_sink_empty_i         (ast_sink_empty_i),
        .ast_sink_startofpacket_i (ast_sink_startofpacket_i),
        .ast_sink_endofpacket_i   (ast_sink_endofpacket_i),
        .windows_data_o           (windows_data_o),
        .windows_valid_bytes_o    (windows_valid_bytes_o),
        .windows_sop_o            (windows_sop_o),
        .windows_eop_o            (windows_eop_o),
        .windows_valid_o          (windows_valid_o),
        .windows_ready_i          (windows_ready_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        string       name;
        logic [15:0] vb;     // window i length at [i*4 +: 4]
        logic        sop;
        logic        eop;
        logic [7:0]  start;  // first stream byte of the beat
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
        end
    endtask

    task automatic timeout(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out", nm);
    endtask

    task automatic push_exp(input string nm, input int v0, input int v1, input int v2,
                            input int v3, input logic sop, input logic eop,
                            input logic [7:0] start);
        exp_t e;
        e.name  = nm;
        e.vb    = {4'(v3), 4'(v2), 4'(v1), 4'(v0)};
        e.sop   = sop;
        e.eop   = eop;
        e.start = start;
        exp_q.push_back(e);
    endtask

    // ---------------------------------------------------------------------
    // Monitor: compare every handed-over beat against the scoreboard
    // ---------------------------------------------------------------------
    exp_t       mon_e;
    logic [7:0] mon_got;
    logic [7:0] mon_want;
    logic       mon_bad;
    int         mon_n;

    always @(negedge clk_i) begin
        if (arst_n_i && windows_valid_o && windows_ready_i) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_beat: got vb=0x%0h sop=%0b eop=%0b, expected none",
                         windows_valid_bytes_o, windows_sop_o, windows_eop_o);
            end else begin
                mon_e = exp_q.pop_front();
                check({mon_e.name, "_vb"}, 64'(windows_valid_bytes_o), 64'(mon_e.vb));
                check({mon_e.name, "_sop"}, 64'(windows_sop_o), 64'(mon_e.sop));
                check({mon_e.name, "_eop"}, 64'(windows_eop_o), 64'(mon_e.eop));
                mon_bad  = 1'b0;
                mon_n    = 0;
                mon_got  = '0;
                mon_want = '0;
                for (int i = 0; i < SYM; i++) begin
                    for (int j = 0; j < MAXW; j++) begin
                        if (j < int'(mon_e.vb[i*4 +: 4]) && !mon_bad) begin
                            mon_n++;
                            mon_got  = windows_data_o[(i*MAXW+j)*8 +: 8];
                            mon_want = mon_e.start + 8'(i + j);
                            if (mon_got !== mon_want) begin
                                mon_bad = 1'b1;
                            end
                        end
                    end
                end
                if (mon_n > 0) begin
                    check({mon_e.name, "_data"}, 64'(mon_got), 64'(mon_want));
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Driver
    // ---------------------------------------------------------------------
    task automatic send_beat(input logic [7:0] b0, input logic sop, input logic eop,
                             input logic [EW-1:0] empty, input logic en,
                             input logic [WSW-1:0] win);
        int cyc;
        ast_sink_data_i          = {b0, b0 + 8'd1, b0 + 8'd2, b0 + 8'd3};
        ast_sink_startofpacket_i = sop;
        ast_sink_endofpacket_i   = eop;
        ast_sink_empty_i         = empty;
        en_i                     = en;
        win_size_i               = win;
        ast_sink_valid_i         = 1'b1;
        cyc = 0;
        @(negedge clk_i);
        while (!ast_sink_ready_o && cyc < 200) begin
            @(negedge clk_i);
            cyc++;
        end
        if (!ast_sink_ready_o) begin
            timeout("sink_accept");
        end
        @(posedge clk_i);
        #1;
        ast_sink_valid_i         = 1'b0;
        ast_sink_startofpacket_i = 1'b0;
        ast_sink_endofpacket_i   = 1'b0;
        ast_sink_empty_i         = '0;
        en_i                     = 1'b1;
    endtask

    task automatic send_packet(input logic [7:0] base, input int nbytes, input logic en,
                               input logic [WSW-1:0] win);
        int nb;
        nb = (nbytes + 3) / 4;
        for (int k = 0; k < nb; k++) begin
            send_beat(base + 8'(4 * k), (k == 0), (k == nb - 1),
                      (k == nb - 1) ? EW'(4 * nb - nbytes) : '0,
                      (k == 0) ? en : 1'b1, win);
        end
    endtask

    task automatic wait_drain(input string nm);
        int cyc;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 300) begin
            @(posedge clk_i);
            cyc++;
        end
        if (exp_q.size() != 0) begin
            timeout({nm, "_drain"});
            exp_q.delete();
        end
        repeat (2) @(posedge clk_i);
        #1;
    endtask

    // ---------------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------------
    logic [SYM*WSW-1:0]    snap_vb;
    logic [SYM*MAXW*8-1:0] snap_data;
    logic                  snap_sop;
    int                    stall_cyc;

    initial begin
        arst_n_i                 = 1'b0;
        en_i                     = 1'b1;
        win_size_i               = 4'd8;
        ast_sink_data_i          = '0;
        ast_sink_valid_i         = 1'b0;
        ast_sink_empty_i         = '0;
        ast_sink_startofpacket_i = 1'b0;
        ast_sink_endofpacket_i   = 1'b0;
        windows_ready_i          = 1'b1;

        // Reset state
        #3;
        check("rst_valid", 64'(windows_valid_o), 64'd0);
        check("rst_sop", 64'(windows_sop_o), 64'd0);
        check("rst_eop", 64'(windows_eop_o), 64'd0);
        check("rst_vb", 64'(windows_valid_bytes_o), 64'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        arst_n_i = 1'b1;
        #1;
        check("rst_sink_ready", 64'(ast_sink_ready_o), 64'd1);
        @(posedge clk_i);
        #1;

        // 1: 12-byte packet, window 8
        push_exp("s1_b1", 8, 8, 8, 8, 1'b1, 1'b0, 8'h00);
        push_exp("s1_b2", 8, Partial ? 7 : 0, Partial ? 6 : 0, Partial ? 5 : 0,
                 1'b0, 1'b0, 8'h04);
        push_exp("s1_b3", Partial ? 4 : 0, Partial ? 3 : 0, Partial ? 2 : 0,
                 Partial ? 1 : 0, 1'b0, 1'b1, 8'h08);
        send_packet(8'h00, 12, 1'b1, 4'd8);
        wait_drain("s1");

        // 2: 3-byte single-beat packet
        push_exp("s2_b1", Partial ? 3 : 0, Partial ? 2 : 0, Partial ? 1 : 0, 0,
                 1'b1, 1'b1, 8'h20);
        send_beat(8'h20, 1'b1, 1'b1, 2'd1, 1'b1, 4'd8);
        wait_drain("s2");

        // 3: window 3, then window 0 (treated as 8)
        push_exp("s3a_b1", 3, 3, 3, 3, 1'b1, 1'b0, 8'h30);
        push_exp("s3a_b2", 3, 3, Partial ? 2 : 0, Partial ? 1 : 0, 1'b0, 1'b1, 8'h34);
        send_packet(8'h30, 8, 1'b1, 4'd3);
        wait_drain("s3a");
        push_exp("s3b_b1", 8, Partial ? 7 : 0, Partial ? 6 : 0, Partial ? 5 : 0,
                 1'b1, 1'b0, 8'h40);
        push_exp("s3b_b2", Partial ? 4 : 0, Partial ? 3 : 0, Partial ? 2 : 0,
                 Partial ? 1 : 0, 1'b0, 1'b1, 8'h44);
        send_packet(8'h40, 8, 1'b1, 4'd0);
        wait_drain("s3b");

        // 4: output stalled for 5 cycles while the packet is still arriving
        push_exp("s4_b1", 8, 8, 8, 8, 1'b1, 1'b0, 8'h50);
        push_exp("s4_b2", 8, 8, 8, 8, 1'b0, 1'b0, 8'h54);
        push_exp("s4_b3", 8, 8, 8, 8, 1'b0, 1'b0, 8'h58);
        push_exp("s4_b4", 8, Partial ? 7 : 0, Partial ? 6 : 0, Partial ? 5 : 0,
                 1'b0, 1'b0, 8'h5c);
        push_exp("s4_b5", Partial ? 4 : 0, Partial ? 3 : 0, Partial ? 2 : 0,
                 Partial ? 1 : 0, 1'b0, 1'b1, 8'h60);
        windows_ready_i = 1'b0;
        fork
            send_packet(8'h50, 20, 1'b1, 4'd8);
            begin
                stall_cyc = 0;
                @(negedge clk_i);
                while (!windows_valid_o && stall_cyc < 50) begin
                    @(negedge clk_i);
                    stall_cyc++;
                end
                if (!windows_valid_o) begin
                    timeout("s4_first_valid");
                end
                snap_vb   = windows_valid_bytes_o;
                snap_data = windows_data_o;
                snap_sop  = windows_sop_o;
                repeat (5) begin
                    @(negedge clk_i);
                    check("s4_hold_valid", 64'(windows_valid_o), 64'd1);
                    check("s4_hold_vb", 64'(windows_valid_bytes_o), 64'(snap_vb));
                    check("s4_hold_sop", 64'(windows_sop_o), 64'(snap_sop));
                    check("s4_hold_data", 64'(windows_data_o === snap_data), 64'd1);
                    check("s4_sink_ready", 64'(ast_sink_ready_o), 64'd0);
                end
                @(posedge clk_i);
                #1;
                windows_ready_i = 1'b1;
            end
        join
        wait_drain("s4");

        // 5: dropped packet, stray beat, then a normal packet
        send_packet(8'h60, 8, 1'b0, 4'd8);
        send_beat(8'h70, 1'b0, 1'b0, 2'd0, 1'b1, 4'd8);
        push_exp("s5_b1", 8, 8, 8, 8, 1'b1, 1'b0, 8'h80);
        push_exp("s5_b2", 8, Partial ? 7 : 0, Partial ? 6 : 0, Partial ? 5 : 0,
                 1'b0, 1'b0, 8'h84);
        push_exp("s5_b3", Partial ? 4 : 0, Partial ? 3 : 0, Partial ? 2 : 0,
                 Partial ? 1 : 0, 1'b0, 1'b1, 8'h88);
        send_packet(8'h80, 12, 1'b1, 4'd8);
        wait_drain("s5");

        // 6: reset while flushing, then recovery
        windows_ready_i = 1'b0;
        send_packet(8'h90, 12, 1'b1, 4'd8);
        check("s6_pre_valid", 64'(windows_valid_o), 64'd1);
        check("s6_pre_sink_ready", 64'(ast_sink_ready_o), 64'd0);
        #2;
        arst_n_i = 1'b0;
        #1;
        check("s6_rst_valid", 64'(windows_valid_o), 64'd0);
        check("s6_rst_sop", 64'(windows_sop_o), 64'd0);
        check("s6_rst_eop", 64'(windows_eop_o), 64'd0);
        check("s6_rst_vb", 64'(windows_valid_bytes_o), 64'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        arst_n_i = 1'b1;
        #1;
        check("s6_rel_sink_ready", 64'(ast_sink_ready_o), 64'd1);
        check("s6_rel_valid", 64'(windows_valid_o), 64'd0);
        @(posedge clk_i);
        #1;
        windows_ready_i = 1'b1;
        send_beat(8'hb0, 1'b0, 1'b1, 2'd0, 1'b1, 4'd8);
        repeat (4) @(posedge clk_i);
        #1;
        push_exp("s6_b1", 8, 8, 8, 8, 1'b1, 1'b0, 8'ha0);
        push_exp("s6_b2", 8, Partial ? 7 : 0, Partial ? 6 : 0, Partial ? 5 : 0,
                 1'b0, 1'b0, 8'ha4);
        push_exp("s6_b3", Partial ? 4 : 0, Partial ? 3 : 0, Partial ? 2 : 0,
                 Partial ? 1 : 0, 1'b0, 1'b1, 8'ha8);
        send_packet(8'ha0, 12, 1'b1, 4'd8);
        wait_drain("s6");
        check("end_valid", 64'(windows_valid_o), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
